// File: rtl/pipe_queue.sv
// Elastic FIFO for a pipeline stage link using the valid/allow_in handshake.
// Supports an optional same-cycle bypass when empty, plus a synchronous flush.
module pipe_queue #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4,
  parameter int BYPASS     = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         in_valid,
  input  logic [DATA_WIDTH-1:0]        in_data,
  output logic                         in_allow_in,
  output logic                         out_valid,
  output logic [DATA_WIDTH-1:0]        out_data,
  input  logic                         out_allow_in,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [PW-1:0] wr_ptr_reg, wr_ptr_next;
  logic [PW-1:0] rd_ptr_reg, rd_ptr_next;
  logic [CW-1:0] count_reg, count_next;

  logic empty;
  logic full;
  logic push;
  logic pop;
  logic pass_through;
  logic wr_en;
  logic rd_en;

  assign empty = (count_reg == '0);
  assign full  = (count_reg == FULL_COUNT);

  // Accept side never looks at out_allow_in, so no ready path crosses the queue.
  assign in_allow_in = !full && !flush;
  assign push        = in_valid && in_allow_in;

  assign out_valid = !flush && (!empty || ((BYPASS != 0) && in_valid));
  assign out_data  = empty ? in_data : mem[rd_ptr_reg];
  assign pop       = out_valid && out_allow_in;

  // A word that is both accepted and consumed while empty never touches storage.
  assign pass_through = empty && push && pop;
  assign wr_en        = push && !pass_through;
  assign rd_en        = pop && !empty;

  assign count = count_reg;

  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    if (flush) begin
      count_next  = '0;
      rd_ptr_next = wr_ptr_reg;
    end else begin
      if (wr_en) wr_ptr_next = wr_ptr_reg + PW'(1);
      if (rd_en) rd_ptr_next = rd_ptr_reg + PW'(1);
      if (wr_en && !rd_en)
        count_next = count_reg + CW'(1);
      else if (!wr_en && rd_en)
        count_next = count_reg - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
    end
  end

  // Storage is intentionally left out of reset; occupancy alone defines validity.
  always_ff @(posedge clk) begin
    if (wr_en)
      mem[wr_ptr_reg] <= in_data;
  end

endmodule

// File: tb/tb_pipe_queue.sv
// Scoreboard bench for pipe_queue: one registered instance and one bypass instance,
// with directed stimulus and monitors that check every popped word.
module tb_pipe_queue;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst0, flush0, iv0, ia0, ov0, oa0;
  logic [7:0] id0, od0;
  logic [2:0] cnt0;
  logic       rst1, flush1, iv1, ia1, ov1, oa1;
  logic [7:0] id1, od1;
  logic [2:0] cnt1;

  pipe_queue #(.DATA_WIDTH(8), .DEPTH(4), .BYPASS(0)) u_q0 (
    .clk(clk), .rst(rst0), .flush(flush0),
    .in_valid(iv0), .in_data(id0), .in_allow_in(ia0),
    .out_valid(ov0), .out_data(od0), .out_allow_in(oa0), .count(cnt0)
  );

  pipe_queue #(.DATA_WIDTH(8), .DEPTH(4), .BYPASS(1)) u_q1 (
    .clk(clk), .rst(rst1), .flush(flush1),
    .in_valid(iv1), .in_data(id1), .in_allow_in(ia1),
    .out_valid(ov1), .out_data(od1), .out_allow_in(oa1), .count(cnt1)
  );

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] q0 [$];
  logic [7:0] q1 [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Monitors: every handshake on the output side is checked against the scoreboard.
  always @(negedge clk) begin
    if (!rst0 && ov0 && oa0) begin
      if (q0.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL pop0_unexpected: got %0h expected no word", od0);
      end else begin
        logic [7:0] e;
        e = q0.pop_front();
        $display("q0 pop data=%0h expect=%0h", od0, e);
        chk("pop0_data", {24'h0, od0}, {24'h0, e});
      end
    end
  end

  always @(negedge clk) begin
    if (!rst1 && ov1 && oa1) begin
      if (q1.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL pop1_unexpected: got %0h expected no word", od1);
      end else begin
        logic [7:0] e;
        e = q1.pop_front();
        $display("q1 pop data=%0h expect=%0h", od1, e);
        chk("pop1_data", {24'h0, od1}, {24'h0, e});
      end
    end
  end

  task automatic drain0(input string name);
    bit done;
    done = 1'b0;
    for (int k = 0; k < 20 && !done; k++) begin
      @(negedge clk);
      if (cnt0 == 3'd0) done = 1'b1;
    end
    chk(name, done, 1);
    chk({name, "_sb_empty"}, q0.size(), 0);
    next_cycle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    bit   done;
    int   idx;
    rst0 = 1; flush0 = 0; iv0 = 0; id0 = 0; oa0 = 0;
    rst1 = 1; flush1 = 0; iv1 = 0; id1 = 0; oa1 = 0;
    next_cycle();
    next_cycle();
    rst0 = 0; rst1 = 0;

    // Reset state
    @(negedge clk);
    chk("rst_count0", cnt0, 0);
    chk("rst_ov0", ov0, 0);
    chk("rst_ia0", ia0, 1);
    chk("rst_count1", cnt1, 0);
    next_cycle();

    // Single word with one cycle of latency
    iv0 = 1; id0 = 8'hA1; oa0 = 1; q0.push_back(8'hA1);
    @(negedge clk);
    chk("lat_ov_c0", ov0, 0);
    next_cycle();
    iv0 = 0;
    @(negedge clk);
    chk("lat_count_c1", cnt0, 1);
    chk("lat_ov_c1", ov0, 1);
    next_cycle();
    @(negedge clk);
    chk("lat_count_c2", cnt0, 0);
    chk("lat_ov_c2", ov0, 0);
    next_cycle();

    // Fill to full, then drain in order
    oa0 = 0;
    for (int i = 1; i <= 5; i++) begin
      iv0 = 1; id0 = 8'(i);
      @(negedge clk);
      if (i <= 4) begin
        chk("fill_ia", ia0, 1);
        q0.push_back(8'(i));
      end else begin
        chk("fill_ia_full", ia0, 0);
        chk("fill_count_full", cnt0, 4);
      end
      next_cycle();
    end
    oa0 = 1;
    @(negedge clk);
    chk("full_pop_ia", ia0, 0);
    chk("full_pop_count", cnt0, 4);
    next_cycle();
    @(negedge clk);
    chk("resume_count", cnt0, 3);
    chk("resume_ia", ia0, 1);
    q0.push_back(8'h05);
    next_cycle();
    iv0 = 0;
    drain0("fill_drain");

    // Flush with entries in flight and a same-cycle push
    oa0 = 0;
    for (int i = 0; i < 3; i++) begin
      iv0 = 1; id0 = 8'h31 + 8'(i); q0.push_back(id0);
      next_cycle();
    end
    flush0 = 1; iv0 = 1; id0 = 8'h44; oa0 = 1;
    q0.delete();
    @(negedge clk);
    chk("flush_ov", ov0, 0);
    chk("flush_ia", ia0, 0);
    chk("flush_count_before", cnt0, 3);
    next_cycle();
    flush0 = 0; id0 = 8'h77; q0.push_back(8'h77);
    @(negedge clk);
    chk("flush_count_after", cnt0, 0);
    chk("flush_ov_after", ov0, 0);
    next_cycle();
    iv0 = 0;
    @(negedge clk);
    chk("flush_push_count", cnt0, 1);
    chk("flush_push_ov", ov0, 1);
    next_cycle();
    drain0("flush_drain");

    // Pointer wrap with random backpressure
    idx = 0; done = 1'b0;
    for (int c = 0; c < 200 && !done; c++) begin
      oa0 = 1'($urandom_range(0, 1));
      iv0 = (idx < 10);
      id0 = 8'h10 + 8'(idx);
      @(negedge clk);
      chk("wrap_count_le4", (cnt0 <= 3'd4), 1);
      if (iv0 && ia0) begin
        q0.push_back(id0);
        idx++;
      end else if (idx == 10 && cnt0 == 3'd0) begin
        done = 1'b1;
      end
      next_cycle();
    end
    iv0 = 0;
    chk("wrap_done", done, 1);
    chk("wrap_sb_empty", q0.size(), 0);

    // Reset in the middle of traffic
    oa0 = 0;
    iv0 = 1; id0 = 8'h61; next_cycle();
    id0 = 8'h62; next_cycle();
    iv0 = 0; rst0 = 1; q0.delete();
    next_cycle();
    rst0 = 0;
    @(negedge clk);
    chk("mrst_count", cnt0, 0);
    chk("mrst_ov", ov0, 0);
    chk("mrst_ia", ia0, 1);
    next_cycle();
    iv0 = 1; id0 = 8'h09; oa0 = 1; q0.push_back(8'h09);
    @(negedge clk);
    chk("mrst_push_ov", ov0, 0);
    next_cycle();
    iv0 = 0;
    @(negedge clk);
    chk("mrst_pop_ov", ov0, 1);
    next_cycle();
    drain0("mrst_drain");

    // Bypass instance: straight through when empty
    iv1 = 1; id1 = 8'h55; oa1 = 1; q1.push_back(8'h55);
    @(negedge clk);
    chk("byp_ov", ov1, 1);
    chk("byp_od", od1, 8'h55);
    chk("byp_count", cnt1, 0);
    next_cycle();
    oa1 = 0; q1.push_back(8'h55);
    @(negedge clk);
    chk("byp_count_stays0", cnt1, 0);
    chk("byp_hold_ov", ov1, 1);
    next_cycle();
    iv1 = 0; oa1 = 1;
    @(negedge clk);
    chk("byp_stored_count", cnt1, 1);
    chk("byp_stored_od", od1, 8'h55);
    next_cycle();
    @(negedge clk);
    chk("byp_empty_count", cnt1, 0);
    chk("byp_empty_ov", ov1, 0);
    next_cycle();

    // Bypass must be suppressed during flush
    flush1 = 1; iv1 = 1; id1 = 8'h66; oa1 = 1;
    @(negedge clk);
    chk("byp_flush_ov", ov1, 0);
    chk("byp_flush_ia", ia1, 0);
    next_cycle();
    flush1 = 0; iv1 = 0;
    @(negedge clk);
    chk("byp_flush_count", cnt1, 0);
    next_cycle();

    // Non-empty bypass queue presents the stored word, not the input
    iv1 = 1; id1 = 8'h81; oa1 = 0; q1.push_back(8'h81);
    next_cycle();
    id1 = 8'h82; oa1 = 1; q1.push_back(8'h82);
    @(negedge clk);
    chk("byp_order_od", od1, 8'h81);
    next_cycle();
    iv1 = 0;
    @(negedge clk);
    chk("byp_order_od2", od1, 8'h82);
    next_cycle();
    @(negedge clk);
    chk("byp_final_count", cnt1, 0);
    chk("byp_sb_empty", q1.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pipe_queue.md
Name: pipe_queue

Overview:
Parametrised elastic buffer for any inter-stage link of the pipelined core (IF->ID, ID->EX, EX->MEM, MEM->WB). It carries the stage bus with the core's valid/allow_in handshake and holds up to DEPTH entries, where the current links hold one register stage. It adds an optional same-cycle bypass and a synchronous flush that discards all in-flight entries on an exception, interrupt or branch redirect.

Parameters:
DATA_WIDTH, 32, width of the stage bus carried (e.g. set to an *_TO_*_BUS_WIDTH define).
DEPTH, 4, number of entries; power of two, >= 2.
BYPASS, 0, 1 = when empty, input is presented on the output in the same cycle; 0 = registered only.

Ports:
clk  input  1  clock; all state updates on the rising edge
rst  input  1  synchronous reset, active-high
flush  input  1  discard all entries and any same-cycle push (redirect/exception)
in_valid  input  1  upstream has a bus word
in_data  input  DATA_WIDTH  upstream bus word
in_allow_in  output  1  queue accepts a push this cycle
out_valid  output  1  a bus word is presented downstream
out_data  output  DATA_WIDTH  presented bus word
out_allow_in  input  1  downstream accepts this cycle
count  output  $clog2(DEPTH+1)  stored entries (registered)

Behaviour:
- Storage: DEPTH x DATA_WIDTH array; write pointer and read pointer of $clog2(DEPTH) bits wrap modulo DEPTH; count is the occupancy, range 0..DEPTH.
- Reset (rst=1 at an edge): count=0, both pointers 0. Array contents are not reset. While count=0: out_valid=0 (BYPASS=0), in_allow_in=1 unless flush.
- in_allow_in = (count != DEPTH) && !flush. There is no combinational path from out_allow_in.
- push = in_valid && in_allow_in.
- out_valid = !flush && ((count != 0) || (BYPASS && in_valid)).
- out_data = mem[rd_ptr] when count != 0; otherwise in_data (bypass). Don't-care when out_valid=0.
- pop = out_valid && out_allow_in.
- Update, non-flush cycle:
  - count != 0: push writes mem[wr_ptr] and increments wr_ptr. Pop increments rd_ptr. count += push - pop. Push and pop together leave count unchanged.
  - count == 0, BYPASS=1, push && pop: the word passes straight through; nothing is stored and pointers and count are unchanged.
  - count == 0, BYPASS=1, push && !pop: the word is stored and count becomes 1. The same word is presented again next cycle.
  - count == 0, BYPASS=0: push stores the word; out_valid first rises the following cycle (1-cycle latency).
- Flush (highest priority below rst): at the edge, count becomes 0 and rd_ptr is set equal to wr_ptr. During the flush cycle no push and no pop occur (in_allow_in=0, out_valid=0).
- Full: in_allow_in=0 even if downstream pops the same cycle; a push resumes the next cycle.
- Empty: pop cannot occur except by bypass; count never underflows.
- Wrap: pointers wrap from DEPTH-1 to 0 with no change to ordering.
- Data order is strict FIFO. A word is never duplicated or lost except by flush.
- rst asserted mid-transfer: same result as flush, and pointers also return to 0.

Test Plan:
- DEPTH=4, BYPASS=0: push 0xA1 at cycle 0 with out_allow_in=1 -> out_valid=1, out_data=0xA1 at cycle 1, count=1 at cycle 1 and 0 at cycle 2.
- Fill: out_allow_in=0, push 0x1,0x2,0x3,0x4,0x5 on consecutive cycles -> count=4, in_allow_in=0 after the 4th push, 0x5 held off. Then out_allow_in=1 -> outputs 0x1..0x4 in order, then 0x5.
- BYPASS=1, empty, in_valid=1, in_data=0x55, out_allow_in=1 -> out_valid=1, out_data=0x55 in the same cycle, count stays 0. Repeat with out_allow_in=0 -> count=1 next cycle, out_data=0x55.
- Flush with count=3 and in_valid=1 in the same cycle -> out_valid=0 and in_allow_in=0 that cycle; count=0 next cycle; the next push 0x77 is the first word popped.
- Wrap: stream 10 words 0x10..0x19 with randomly toggled out_allow_in -> output sequence is exactly 0x10..0x19, count never exceeds 4.
- rst=1 asserted for one cycle with count=2 -> count=0 and out_valid=0 (BYPASS=0) next cycle; a subsequent push 0x9 pops as 0x9.
